// File: rtl/multi_digit_counter.sv
// Multi-digit decimal/hex up/down counter with a programmable step rate,
// per-digit load, and a multiplexed active-low 7-segment display scanner.
module multi_digit_counter #(
  parameter int  DIGITS      = 8,
  parameter int  SPEED_W     = 6,
  parameter int  BASE_DIV    = 1,
  parameter int  REFRESH_DIV = 4,
  localparam int SEL_W       = $clog2(DIGITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  upDown,
  input  logic                  load,
  input  logic [SEL_W-1:0]      loadSelect,
  input  logic [3:0]            loadValue,
  input  logic [SPEED_W-1:0]    speed,
  input  logic                  hexMode,
  input  logic                  wrapEn,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  carry,
  output logic [6:0]            AtoG,
  output logic [DIGITS-1:0]     anode,
  output logic                  DP,
  output logic                  loadLED,
  output logic                  enLED,
  output logic                  upDownLED
);

  localparam int DIV_W = $clog2((2 ** SPEED_W) * BASE_DIV + 1);
  localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  logic [DIGITS-1:0][3:0] cnt;
  logic [DIGITS-1:0][3:0] step_cnt;
  logic                   full_wrap;
  logic [DIV_W-1:0]       div;
  logic [DIV_W-1:0]       period_m1;
  logic                   step_req;
  logic [REF_W-1:0]       ref_cnt;
  logic [SEL_W-1:0]       scan_idx;
  logic [3:0]             radix_m1;
  logic [3:0]             load_val;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      default: seg7 = 7'b0111000;
    endcase
  endfunction

  assign count     = cnt;
  assign loadLED   = load;
  assign enLED     = en;
  assign upDownLED = upDown;

  assign radix_m1  = hexMode ? 4'hF : 4'd9;
  assign load_val  = (!hexMode && loadValue > 4'd9) ? 4'd9 : loadValue;
  assign period_m1 = DIV_W'((32'(speed) + 1) * BASE_DIV - 1);
  // A shortened period takes effect at once: a divider already past the new end fires now.
  assign step_req  = (div >= period_m1);

  // Ripple the step through the digits; full_wrap means it fell off the top digit.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    logic ripple;
    step_cnt = cnt;
    ripple   = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (ripple) begin
        if (upDown) begin
          if (cnt[k] >= radix_m1) begin
            step_cnt[k] = 4'd0;
          end else begin
            step_cnt[k] = cnt[k] + 4'd1;
            ripple      = 1'b0;
          end
        end else if (cnt[k] == 4'd0) begin
          step_cnt[k] = radix_m1;
        end else if (cnt[k] > radix_m1) begin
          step_cnt[k] = radix_m1;
          ripple      = 1'b0;
        end else begin
          step_cnt[k] = cnt[k] - 4'd1;
          ripple      = 1'b0;
        end
      end
    end
    full_wrap = ripple;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      div   <= '0;
      cnt   <= '0;
      tick  <= 1'b0;
      carry <= 1'b0;
    end else begin
      div   <= step_req ? '0 : div + DIV_W'(1);
      tick  <= 1'b0;
      carry <= 1'b0;
      if (load) begin
        for (int k = 0; k < DIGITS; k++) begin
          if (loadSelect == SEL_W'(k)) cnt[k] <= load_val;
        end
      end else if (en && step_req) begin
        tick <= 1'b1;
        if (!full_wrap) begin
          cnt <= step_cnt;
        end else if (wrapEn) begin
          cnt   <= step_cnt;
          carry <= 1'b1;
        end
      end
    end
  end

  // Display scan: each digit is driven for REFRESH_DIV cycles in turn.
  always_ff @(posedge clk) begin
    if (reset) begin
      ref_cnt  <= '0;
      scan_idx <= '0;
      anode    <= ~DIGITS'(1);
      AtoG     <= 7'b0000001;
      DP       <= 1'b1;
    end else begin
      if (ref_cnt == REF_W'(REFRESH_DIV - 1)) begin
        ref_cnt  <= '0;
        scan_idx <= (scan_idx == SEL_W'(DIGITS - 1)) ? '0 : scan_idx + SEL_W'(1);
      end else begin
        ref_cnt <= ref_cnt + REF_W'(1);
      end
      anode <= ~(DIGITS'(1) << scan_idx);
      AtoG  <= seg7(cnt[scan_idx]);
      DP    <= !(load && (loadSelect == scan_idx));
    end
  end

endmodule
